fifo_flow_ctrl_fsm: RTL
=======================

// Module: fifo_flow_ctrl_fsm
// PURPOSE
//  Multi-channel FIFO flow-control state machine. Watches per-FIFO occupancy and overflow,
//  and drives per-channel pausa/continua to the upstream source. Thresholds are programmable
//  during INIT, and pause uses hysteresis. Errors are sticky and reported per channel.
//  Sits between the FIFO bank and the source arbiter in the datapath.
// PARAMETERS
//  NUM_FIFOS   4   number of monitored FIFOs/channels
//  FIFO_DEPTH  8   depth of each FIFO (entries)
//  CNT_W       4   occupancy width, = $clog2(FIFO_DEPTH)+1
//  AF_DEFAULT  6   almost-full threshold used after reset or on invalid config
//  AE_DEFAULT  2   almost-empty threshold used after reset or on invalid config
// PORTS
//  clk          in   1                single clock, rising edge
//  reset        in   1                asynchronous reset, active-high
//  init         in   1                enter/stay in INIT, capture configuration
//  cfg_af_thr   in   CNT_W            almost-full threshold, sampled in INIT
//  cfg_ae_thr   in   CNT_W            almost-empty threshold, sampled in INIT
//  fifo_count   in   NUM_FIFOS*CNT_W  occupancy per FIFO; channel i = [i*CNT_W +: CNT_W]
//  fifo_ovf     in   NUM_FIFOS        per-FIFO overflow strobe
//  state        out  3                current FSM state encoding
//  pausa        out  NUM_FIFOS        per-channel pause request to source
//  continua     out  NUM_FIFOS        per-channel continue grant to source
//  error_full   out  NUM_FIFOS        sticky per-channel overflow flag
//  idle         out  1                1 when all FIFOs empty in IDLE
//  cfg_err      out  1                last INIT captured invalid thresholds
// BEHAVIOUR
//  - Reset: state=RESET, pausa=0, continua=0, error_full=0, idle=0, cfg_err=0,
//    thresholds = AF_DEFAULT/AE_DEFAULT. Reset mid-operation aborts immediately (async).
//  - All outputs are registered: 1-cycle latency from sampled inputs.
//  - States: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
//  - RESET -> INIT when init=1. Otherwise stays in RESET.
//  - INIT: cfg thresholds are captured every cycle. INIT -> IDLE when init=0.
//    On exit, if cfg_ae_thr >= cfg_af_thr or cfg_af_thr > FIFO_DEPTH, load defaults and set
//    cfg_err=1. Otherwise cfg_err=0. Outputs in INIT: pausa=all 1, continua=0.
//  - IDLE: idle=1, continua=all 1, pausa=0. IDLE -> ACTIVE when any count != 0.
//  - ACTIVE: per channel i, with hysteresis:
//    - pausa[i] sets when count_i >= af_thr.
//    - pausa[i] clears when count_i <= ae_thr.
//    - Otherwise pausa[i] holds.
//    - continua[i] = ~pausa[i].
//    ACTIVE -> IDLE when all counts == 0. Clears all pausa.
//  - ERROR entry: from IDLE or ACTIVE when any fifo_ovf[i]=1, or when any count_i > FIFO_DEPTH.
//  - In ERROR: error_full accumulates (OR) offending channels, pausa=all 1, continua=0.
//  - ERROR exits only via reset, or via init=1 (-> INIT).
//  - error_full is cleared on INIT entry.
//  - init=1 in IDLE/ACTIVE/ERROR -> INIT next cycle. init has priority over overflow.
//  - Overflow in the same cycle as the ACTIVE->IDLE condition: ERROR wins.
//  - Comparisons are unsigned, CNT_W bits. count == threshold counts as reaching it.
// STRUCTURE
//  - Shared package fifo_fc_pkg: state localparams (S_RESET..S_ERROR) and state width 3.
//  - Sub-module fc_channel (one per FIFO, generate loop):
//    - inputs: count, af_thr, ae_thr, active.
//    - owns the pausa hysteresis flop.
//    - outputs: pausa, ovf_detect.
//  - Top holds the FSM, the threshold/cfg_err registers and error_full.
// TESTING
//  1. reset=1 10 cycles, then 0, init=0:
//     -> state=0, all outputs 0, stays RESET.
//  2. init=1 with cfg_af_thr=5, cfg_ae_thr=1, then init=0:
//     -> state 1 -> 2, cfg_err=0, idle=1, continua=4'hF.
//  3. ch0 count 0->3->5->4->2->1:
//     -> pausa[0] rises 1 clk after 5, holds through 4 and 2, falls 1 clk after 1.
//     -> continua[0] is its complement. Other channels unaffected.
//  4. INIT with af=2, ae=3 (invalid):
//     -> cfg_err=1, thresholds 6/2. ch1 count=6 -> pausa[1]=1.
//  5. ACTIVE, fifo_ovf=4'b0100 then 4'b0001:
//     -> state=4, error_full=4'b0101, pausa=4'hF, continua=0.
//     -> init=1 -> INIT and error_full=0.
//  6. reset asserted mid-ACTIVE with pausa=4'h3:
//     -> all outputs 0 without waiting for clk edge.
//  7. Simultaneous overflow and all counts 0 -> ERROR.
//     init=1 with overflow -> INIT.

Source files
------------

// File: rtl/fifo_fc_pkg.sv
// Shared definitions for the FIFO flow-control FSM: state encoding and
// threshold validation helper.
package fifo_fc_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } fc_state_e;

  // A threshold pair is usable only if empty-side sits strictly below the
  // full-side and the full-side is reachable by a FIFO of the given depth.
  function automatic logic thr_valid(input int af, input int ae, input int depth);
    return (ae < af) && (af <= depth);
  endfunction

endpackage

// File: rtl/fc_channel.sv
// One flow-control channel: pause hysteresis flop, continue grant flop and
// combinational overflow/over-occupancy detection for a single FIFO.
module fc_channel
  import fifo_fc_pkg::*;
#(
  parameter int CNT_W      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] count,
  input  logic [CNT_W-1:0] af_thr,
  input  logic [CNT_W-1:0] ae_thr,
  input  logic             ovf,
  input  logic             active,      // FSM is (entering or staying) in ACTIVE
  input  logic             hold_pause,  // FSM is heading to INIT or ERROR
  input  logic             grant,       // FSM is heading to IDLE
  output logic             pausa,
  output logic             continua,
  output logic             ovf_detect
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic pausa_hyst;

  // Hysteresis: reaching af sets, dropping to ae clears, in between holds.
  always_comb begin
    pausa_hyst = pausa;
    if (count >= af_thr) begin
      pausa_hyst = 1'b1;
    end else if (count <= ae_thr) begin
      pausa_hyst = 1'b0;
    end
  end

  assign ovf_detect = ovf | (count > DEPTH_C);

  // Registered pause/continue; ACTIVE is only reachable from IDLE or itself,
  // so the held value on ACTIVE entry is always the cleared IDLE value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pausa    <= 1'b0;
      continua <= 1'b0;
    end else if (hold_pause) begin
      pausa    <= 1'b1;
      continua <= 1'b0;
    end else if (active) begin
      pausa    <= pausa_hyst;
      continua <= ~pausa_hyst;
    end else begin
      pausa    <= 1'b0;
      continua <= grant;
    end
  end

endmodule

// File: rtl/fifo_flow_ctrl_fsm.sv
// Multi-channel FIFO flow-control FSM: programmable thresholds captured in
// INIT, per-channel pause with hysteresis, sticky per-channel error flags.
module fifo_flow_ctrl_fsm
  import fifo_fc_pkg::*;
#(
  parameter int NUM_FIFOS  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4,
  parameter int AF_DEFAULT = 6,
  parameter int AE_DEFAULT = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init,
  input  logic [CNT_W-1:0]           cfg_af_thr,
  input  logic [CNT_W-1:0]           cfg_ae_thr,
  input  logic [NUM_FIFOS*CNT_W-1:0] fifo_count,
  input  logic [NUM_FIFOS-1:0]       fifo_ovf,
  output logic [STATE_W-1:0]         state,
  output logic [NUM_FIFOS-1:0]       pausa,
  output logic [NUM_FIFOS-1:0]       continua,
  output logic [NUM_FIFOS-1:0]       error_full,
  output logic                       idle,
  output logic                       cfg_err
);

  localparam logic [CNT_W-1:0] AF_DEF = CNT_W'(AF_DEFAULT);
  localparam logic [CNT_W-1:0] AE_DEF = CNT_W'(AE_DEFAULT);

  fc_state_e          state_reg;
  fc_state_e          state_next;
  logic [CNT_W-1:0]   af_thr_reg;
  logic [CNT_W-1:0]   ae_thr_reg;
  logic [NUM_FIFOS-1:0] ovf_detect;
  logic [NUM_FIFOS-1:0] nonzero;
  logic               any_err;
  logic               all_zero;
  logic               cfg_ok;

  assign state    = state_reg;
  assign any_err  = |ovf_detect;
  assign all_zero = ~(|nonzero);
  assign cfg_ok   = thr_valid(int'(cfg_af_thr), int'(cfg_ae_thr), FIFO_DEPTH);

  generate
    for (genvar gi = 0; gi < NUM_FIFOS; gi++) begin : g_ch
      assign nonzero[gi] = |fifo_count[gi*CNT_W +: CNT_W];

      fc_channel #(
        .CNT_W      (CNT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_ch (
        .clk        (clk),
        .reset      (reset),
        .count      (fifo_count[gi*CNT_W +: CNT_W]),
        .af_thr     (af_thr_reg),
        .ae_thr     (ae_thr_reg),
        .ovf        (fifo_ovf[gi]),
        .active     (state_next == S_ACTIVE),
        .hold_pause ((state_next == S_INIT) || (state_next == S_ERROR)),
        .grant      (state_next == S_IDLE),
        .pausa      (pausa[gi]),
        .continua   (continua[gi]),
        .ovf_detect (ovf_detect[gi])
      );
    end
  endgenerate

  // Next-state decode: init beats overflow, overflow beats the drain-to-IDLE.
  always_comb begin
    state_next = state_reg;
    if (init) begin
      state_next = S_INIT;
    end else begin
      case (state_reg)
        S_RESET:  state_next = S_RESET;
        S_INIT:   state_next = S_IDLE;
        S_IDLE:   state_next = any_err ? S_ERROR : (all_zero ? S_IDLE : S_ACTIVE);
        S_ACTIVE: state_next = any_err ? S_ERROR : (all_zero ? S_IDLE : S_ACTIVE);
        S_ERROR:  state_next = S_ERROR;
        default:  state_next = S_RESET;
      endcase
    end
  end

  // FSM state, threshold capture and the registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= S_RESET;
      af_thr_reg <= AF_DEF;
      ae_thr_reg <= AE_DEF;
      cfg_err    <= 1'b0;
      error_full <= '0;
      idle       <= 1'b0;
    end else begin
      state_reg <= state_next;
      idle      <= (state_next == S_IDLE) && all_zero;

      // Thresholds follow the config inputs every INIT cycle; the value seen
      // on the exit edge is the one that sticks.
      if (state_reg == S_INIT) begin
        if (cfg_ok) begin
          af_thr_reg <= cfg_af_thr;
          ae_thr_reg <= cfg_ae_thr;
          cfg_err    <= 1'b0;
        end else begin
          af_thr_reg <= AF_DEF;
          ae_thr_reg <= AE_DEF;
          cfg_err    <= 1'b1;
        end
      end

      if (state_next == S_INIT) begin
        error_full <= '0;
      end else if (state_next == S_ERROR) begin
        error_full <= error_full | ovf_detect;
      end
    end
  end

endmodule
